// File: rtl/regfile_wb_arbiter.sv
// regfile_wb_arbiter: sole owner of the register-memory write port; round-robin ALU/load writeback, x0 drop, zero sweep.
// Latency: handshake at edge N drives rf_we/rf_rd/rf_wdata after edge N, memory captures them at edge N+1; 1 write/cycle.
// Backpressure: combinational readys, at most one high; both low during a sweep and on the clear_req cycle; loser holds.
module regfile_wb_arbiter #(
  parameter int DATA_W  = 64,
  parameter int IDX_W   = 6,
  parameter int NREGS   = 32,
  parameter int ZERO_X0 = 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_req,
  input  logic              wb0_valid,
  input  logic [IDX_W-1:0]  wb0_rd,
  input  logic [DATA_W-1:0] wb0_data,
  output logic              wb0_ready,
  input  logic              wb1_valid,
  input  logic [IDX_W-1:0]  wb1_rd,
  input  logic [DATA_W-1:0] wb1_data,
  output logic              wb1_ready,
  output logic              rf_we,
  output logic [IDX_W-1:0]  rf_rd,
  output logic [DATA_W-1:0] rf_wdata,
  output logic              busy,
  output logic              clear_done
);

  // Index bits that actually address a register; anything above is ignored.
  localparam int AW = (NREGS > 1) ? $clog2(NREGS) : 1;

  typedef enum logic {
    S_CLEAR = 1'b0,
    S_RUN   = 1'b1
  } state_t;

  state_t             state;
  state_t             state_nxt;
  logic [IDX_W-1:0]   idx;
  logic [IDX_W-1:0]   idx_nxt;
  logic               clear_last;

  // rr_last: 0 = wb0 won the last handshake, 1 = wb1 won it.
  logic               rr_last;
  logic               grant0;
  logic               grant1;
  logic               hs;
  logic [AW-1:0]      sel_idx;
  logic [DATA_W-1:0]  sel_data;
  logic               sel_drop;

  // Upper index bits carry no address information; keep them referenced.
  logic [2*IDX_W-1:0] rd_unused;
  assign rd_unused = {wb0_rd, wb1_rd};

  assign clear_last = (idx == IDX_W'(NREGS - 1));

  // State register: reset lands in CLEAR at index 0 so the file is zeroed first.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= S_CLEAR;
      idx   <= '0;
    end else begin
      state <= state_nxt;
      idx   <= idx_nxt;
    end
  end

  // Next-state: sweep runs to NREGS-1 then RUN; clear_req in RUN restarts the sweep.
  always_comb begin
    state_nxt = state;
    idx_nxt   = idx;
    case (state)
      S_CLEAR: begin
        if (clear_last) begin
          state_nxt = S_RUN;
          idx_nxt   = '0;
        end else begin
          idx_nxt = idx + IDX_W'(1);
        end
      end
      S_RUN: begin
        if (clear_req) begin
          state_nxt = S_CLEAR;
          idx_nxt   = '0;
        end
      end
      default: begin
        state_nxt = S_CLEAR;
        idx_nxt   = '0;
      end
    endcase
  end

  // Output decode: round-robin grant in RUN, suppressed by a sweep or a clear request.
  always_comb begin
    grant0 = 1'b0;
    grant1 = 1'b0;
    if (state == S_RUN && !clear_req) begin
      if (wb0_valid && wb1_valid) begin
        grant0 = rr_last;
        grant1 = !rr_last;
      end else begin
        grant0 = wb0_valid;
        grant1 = wb1_valid;
      end
    end
  end

  assign wb0_ready = grant0;
  assign wb1_ready = grant1;
  assign busy      = (state == S_CLEAR);

  // Winner's payload; only the addressing bits of rd are kept.
  assign hs       = grant0 | grant1;
  assign sel_idx  = grant1 ? wb1_rd[AW-1:0] : wb0_rd[AW-1:0];
  assign sel_data = grant1 ? wb1_data : wb0_data;
  assign sel_drop = (ZERO_X0 != 0) && (sel_idx == '0);

  // Write-port register: sweep writes zero to idx, otherwise forward the winner.
  // A dropped x0 write behaves like no write: rf_rd/rf_wdata keep their values.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rf_we      <= 1'b0;
      rf_rd      <= '0;
      rf_wdata   <= '0;
      clear_done <= 1'b0;
      rr_last    <= 1'b1;
    end else begin
      clear_done <= (state == S_CLEAR) && clear_last;
      if (state == S_CLEAR) begin
        rf_we    <= 1'b1;
        rf_rd    <= idx;
        rf_wdata <= '0;
      end else if (hs) begin
        rr_last <= grant1;
        rf_we   <= !sel_drop;
        if (!sel_drop) begin
          rf_rd    <= IDX_W'(sel_idx);
          rf_wdata <= sel_data;
        end
      end else begin
        rf_we <= 1'b0;
      end
    end
  end

`ifndef SYNTHESIS
  // Grants are mutually exclusive and never given while sweeping.
  a_one_grant : assert property (@(posedge clk) disable iff (!rst_n)
    !(wb0_ready && wb1_ready));
  a_no_grant_busy : assert property (@(posedge clk) disable iff (!rst_n)
    busy |-> !(wb0_ready || wb1_ready));
`endif

endmodule
